// File: rtl/inv_round_sequencer_if.sv
// Job/result handshake bundle for the AES-128 inverse round sequencer.
// master: the side that submits ciphertext and consumes plaintext.
// slave:  the sequencer itself.
interface inv_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_num;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy, round_num
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy, round_num
    );
endinterface

// File: rtl/inv_round_sequencer.sv
// Iterative AES-128 decryption: one inverse round per clock.
// The job supplies the round-10 key; earlier round keys are regenerated on
// the fly by running the key expansion backwards, so no key RAM is needed.
// The S-boxes are built from GF(2^8) inversion plus the affine map.
module inv_round_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    inv_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [127:0] out_data_reg, out_data_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic         out_valid_reg, out_valid_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Rcon of the key being undone: key_reg holds K(11-rnd), k_next is K(10-rnd).
    logic [7:0] rcon;
    always_comb begin
        rcon = 8'h00;
        case (rnd_reg)
            4'd1:    rcon = 8'h36;
            4'd2:    rcon = 8'h1b;
            4'd3:    rcon = 8'h80;
            4'd4:    rcon = 8'h40;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h10;
            4'd7:    rcon = 8'h08;
            4'd8:    rcon = 8'h04;
            4'd9:    rcon = 8'h02;
            4'd10:   rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    // Backward key step: undo w[i] = w[i-4] ^ f(w[i-1]) for one round key.
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  p3_rot, p3_sub;
    logic [127:0] k_next;

    assign n0     = key_reg[127:96];
    assign n1     = key_reg[95:64];
    assign n2     = key_reg[63:32];
    assign n3     = key_reg[31:0];
    assign p3     = n3 ^ n2;
    assign p2     = n2 ^ n1;
    assign p1     = n1 ^ n0;
    assign p3_rot = {p3[23:0], p3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sub
            assign p3_sub[31-8*gi -: 8] = sbox(p3_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign k_next = {n0 ^ p3_sub ^ {rcon, 24'h000000}, p1, p2, p3};

    // InvShiftRows folded into the byte routing feeding InvSubBytes.
    logic [127:0] sb_flat;
    logic [127:0] ark;
    logic [127:0] mix;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign sb_flat[127-8*gi -: 8] = inv_sbox(state_reg[127-8*SRC -: 8]);
        end
    endgenerate

    // Same AddRoundKey serves ROUND and LAST: in LAST k_next is the round-0 key.
    assign ark = sb_flat ^ k_next;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign mix[127-32*gi -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
            };
        end
    endgenerate

    // Next-state and datapath register updates for the job sequence.
    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        key_next       = key_reg;
        rnd_next       = rnd_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;

        if (rnd_reg > 4'd10) begin
            // Unreachable round index: drop the job and recover.
            fsm_next       = IDLE;
            rnd_next       = 4'd0;
            out_valid_next = 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_next = bus.in_data ^ bus.in_key;
                        key_next   = bus.in_key;
                        rnd_next   = 4'd1;
                        fsm_next   = ROUND;
                    end
                end
                ROUND: begin
                    state_next = mix;
                    key_next   = k_next;
                    rnd_next   = rnd_reg + 4'd1;
                    if (rnd_reg == 4'd9) fsm_next = LAST;
                end
                LAST: begin
                    out_data_next  = ark;
                    out_valid_next = 1'b1;
                    rnd_next       = 4'd0;
                    fsm_next       = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_next = 1'b0;
                        fsm_next       = IDLE;
                    end
                end
                default: begin
                    fsm_next = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset; reset also aborts any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            key_reg       <= '0;
            rnd_reg       <= 4'd0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            state_reg     <= state_next;
            key_reg       <= key_next;
            rnd_reg       <= rnd_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = (fsm_reg == IDLE);
    assign bus.busy      = (fsm_reg == ROUND) || (fsm_reg == LAST);
    assign bus.round_num = rnd_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
endmodule

// File: tb/tb_inv_round_sequencer.sv
// Bench for inv_round_sequencer: known-answer table, randomized jobs checked
// against a textbook AES-128 inverse cipher model, and hand-written sequences
// for reset abort and back-to-back operation.
module tb_inv_round_sequencer;
    logic clk;
    logic rst;

    inv_round_sequencer_if bus ();

    inv_round_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Generator walk: p runs over powers of 3, q over powers of 3^-1.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon_of(input int i);
        case (i)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic [127:0] k10);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] res;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rcon_of(i / 4);
            end
            w[i-4] = w[i] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = s[r][(c - r + 4) % 4];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = inv_t[t[r][c]] ^ w[4*rnd+c][31-8*r -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    c0 = s[0][c]; c1 = s[1][c]; c2 = s[2][c]; c3 = s[3][c];
                    s[0][c] = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
                    s[1][c] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
                    s[2][c] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
                    s[3][c] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete job: submit, watch rounds, hold off out_ready for 'hold'
    // extra cycles, then complete the handshake.
    task automatic run_job(input string name, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp, input bit interfere, input int hold);
        int lat;
        int waited;
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_data   = ct;
        bus.in_key    = k;
        bus.in_valid  = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check({name, " in_ready before accept"}, bus.in_ready, 1'b1);
        @(posedge clk);
        lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                bus.in_valid = 1'b0;
                lat = t;
                break;
            end
            if (interfere) begin
                bus.in_valid = 1'($urandom);
                bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
                bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.in_valid = 1'b0;
            end
            check({name, " round_num"}, bus.round_num, 128'(t + 1));
            check({name, " busy in round"}, bus.busy, 1'b1);
            check({name, " in_ready in round"}, bus.in_ready, 1'b0);
        end
        check({name, " latency"}, 128'(lat), 128'd10);
        check({name, " out_data"}, bus.out_data, exp);
        check({name, " round_num done"}, bus.round_num, 4'd0);
        check({name, " busy done"}, bus.busy, 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            check({name, " held out_valid"}, bus.out_valid, 1'b1);
            check({name, " held out_data"}, bus.out_data, exp);
            check({name, " held in_ready"}, bus.in_ready, 1'b0);
            check({name, " held busy"}, bus.busy, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, " out_valid after handshake"}, bus.out_valid, 1'b0);
        check({name, " in_ready after handshake"}, bus.in_ready, 1'b1);
        check({name, " out_data kept"}, bus.out_data, exp);
        $display("job %s: ct=%h key=%h pt=%h latency=%0d hold=%0d", name, ct, k, bus.out_data, lat, hold);
    endtask

    typedef struct {
        string        name;
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
        bit           interfere;
        int           hold;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rct, rkey;
        int first_t, second_t;
        logic [127:0] first_d, second_d;

        build_tables();
        vecs[0] = '{"C1",           C1_CT, C1_KEY, C1_PT, 1'b0, 0};
        vecs[1] = '{"B",            B_CT,  B_KEY,  B_PT,  1'b0, 0};
        vecs[2] = '{"C1_interfere", C1_CT, C1_KEY, C1_PT, 1'b1, 0};
        vecs[3] = '{"C1_backpress", C1_CT, C1_KEY, C1_PT, 1'b0, 20};
        vecs[4] = '{"B_mixed",      B_CT,  B_KEY,  B_PT,  1'b1, 3};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset out_data", bus.out_data, 128'h0);
        check("reset round_num", bus.round_num, 4'd0);
        $display("reset: in_ready=%b out_valid=%b busy=%b", bus.in_ready, bus.out_valid, bus.busy);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_job(vecs[i].name, vecs[i].ct, vecs[i].key, vecs[i].pt, vecs[i].interfere, vecs[i].hold);

        for (int i = 0; i < 8; i++) begin
            rct  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_job($sformatf("rand%0d", i), rct, rkey, model_decrypt(rct, rkey),
                    1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset sampled at E5 aborts the job with no output.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data   = C1_CT;
        bus.in_key    = C1_KEY;
        bus.in_valid  = 1'b1;
        check("abort in_ready before accept", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort out_valid", bus.out_valid, 1'b0);
        check("abort out_data", bus.out_data, 128'h0);
        check("abort busy", bus.busy, 1'b0);
        check("abort in_ready", bus.in_ready, 1'b1);
        check("abort round_num", bus.round_num, 4'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort no output", bus.out_valid, 1'b0);
        end
        $display("reset mid-job: aborted at E5");
        run_job("B_after_abort", B_CT, B_KEY, B_PT, 1'b0, 0);

        // Back-to-back with in_valid held high: outputs 12 cycles apart.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data   = C1_CT;
        bus.in_key    = C1_KEY;
        bus.in_valid  = 1'b1;
        check("b2b in_ready before accept", bus.in_ready, 1'b1);
        @(posedge clk);
        first_t = -1; second_t = -1;
        first_d = '0; second_d = '0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (t == 0) begin
                bus.in_data = B_CT;
                bus.in_key  = B_KEY;
            end
            if (bus.out_valid) begin
                if (first_t < 0) begin
                    first_t = t;
                    first_d = bus.out_data;
                end else begin
                    second_t = t;
                    second_d = bus.out_data;
                    bus.in_valid = 1'b0;
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("b2b first time", 128'(first_t), 128'd10);
        check("b2b first data", first_d, C1_PT);
        check("b2b second time", 128'(second_t), 128'd22);
        check("b2b second data", second_d, B_PT);
        @(negedge clk);
        check("b2b idle after", bus.in_ready, 1'b1);
        check("b2b busy after", bus.busy, 1'b0);
        $display("back-to-back: first at %0d (%h) second at %0d (%h)", first_t, first_d, second_t, second_d);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
